fetch_align_queue: RTL

Parametrised instruction-fetch queue and aligner between the instruction memory port and decode. It generates sequential word fetch addresses and buffers returned 32-bit words as 16-bit halfword entries tagged with their PC. It presents one aligned instruction per cycle, either a 16-bit compressed instruction or a 32-bit instruction spanning a word boundary. It replaces the fixed single-word buffer with configurable depth, misaligned redirect handling and discard of stale responses.

---
 rtl/fetch_align_queue_pkg.sv | 55 +++++
 rtl/fetch_align_queue_if.sv | 26 ++
 rtl/fetch_align_ram.sv | 32 +++
 rtl/fetch_align_queue.sv | 132 +++++++++++++
 4 files changed

// File: rtl/fetch_align_queue_pkg.sv
// rtl/fetch_align_queue_pkg.sv - shared types and helpers for the fetch queue/aligner
package fetch_align_queue_pkg;

  localparam int HW_W    = 16;
  localparam int ENTRY_W = HW_W + 32;

  // wires
  typedef struct packed {
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        redirect_fence;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        out_stall;
  } fetch_queue_in_type;

  typedef struct packed {
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_spec;
    logic        mem_fence;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
  } fetch_queue_out_type;

  typedef struct packed {
    logic [31:0] fetch_pc;
    logic        pend;
    logic        drop;
    logic        spec_f;
    logic        fence_f;
  } fetch_queue_reg_type;

  typedef struct packed {
    logic [HW_W-1:0] hw;
    logic [31:0]     pc;
  } fetch_entry_type;

  function automatic fetch_queue_reg_type init_fetch_queue_reg(input logic [31:0] reset_pc);
    fetch_queue_reg_type v;
    v.fetch_pc = reset_pc;
    v.pend     = 1'b0;
    v.drop     = 1'b0;
    v.spec_f   = 1'b1;
    v.fence_f  = 1'b0;
    return v;
  endfunction

  // functions
  function automatic logic is_compressed(input logic [HW_W-1:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_queue_if.sv
// rtl/fetch_align_queue_if.sv - redirect, memory and decode-side signals of the fetch queue
interface fetch_align_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        redirect_fence;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_spec;
  logic        mem_fence;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_stall;

  modport master (
    input  redirect, redirect_pc, redirect_fence, mem_ready, mem_rdata, out_stall,
    output mem_valid, mem_addr, mem_spec, mem_fence, out_valid, out_pc, out_instr
  );

  modport slave (
    output redirect, redirect_pc, redirect_fence, mem_ready, mem_rdata, out_stall,
    input  mem_valid, mem_addr, mem_spec, mem_fence, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/fetch_align_ram.sv
// rtl/fetch_align_ram.sv - halfword+pc storage, two write ports and two read ports
module fetch_align_ram
  import fetch_align_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            we0,
  input  logic [AW-1:0]   waddr0,
  input  fetch_entry_type wdata0,
  input  logic            we1,
  input  logic [AW-1:0]   waddr1,
  input  fetch_entry_type wdata1,
  input  logic [AW-1:0]   raddr0,
  output fetch_entry_type rdata0,
  input  logic [AW-1:0]   raddr1,
  output logic [HW_W-1:0] rdata1_hw
);

  fetch_entry_type mem [DEPTH];

  // The two write addresses are always adjacent slots, so they never collide.
  always_ff @(posedge clock) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0    = mem[raddr0];
  assign rdata1_hw = mem[raddr1].hw;

endmodule

// File: rtl/fetch_align_queue.sv
// rtl/fetch_align_queue.sv - sequential fetch request generator and halfword instruction aligner
module fetch_align_queue
  import fetch_align_queue_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic                 clock,
  input logic                 reset,
  fetch_align_queue_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  fetch_queue_in_type  d_in;
  fetch_queue_out_type d_out;
  fetch_queue_reg_type r, rin;

  ptr_t            head, tail, head_n, tail_n;
  cnt_t            count, count_n, free;
  fetch_entry_type rd0, wr0, wr1;
  logic [HW_W-1:0] rd1_hw;
  logic            we0, we1, resp, accept, head_c, have_instr;
  logic [1:0]      push_n, pop_n;

  assign d_in = fetch_queue_in_type'{
    redirect:       bus.redirect,
    redirect_pc:    bus.redirect_pc,
    redirect_fence: bus.redirect_fence,
    mem_ready:      bus.mem_ready,
    mem_rdata:      bus.mem_rdata,
    out_stall:      bus.out_stall
  };

  always_comb begin
    free   = cnt_t'(DEPTH) - count;
    resp   = r.pend && d_in.mem_ready;
    accept = resp && !r.drop && !d_in.redirect;

    // fetch_pc already carries the halfword offset, so it is the pc of the first pushed entry.
    wr0.hw = r.fetch_pc[1] ? d_in.mem_rdata[31:16] : d_in.mem_rdata[15:0];
    wr0.pc = r.fetch_pc;
    wr1.hw = d_in.mem_rdata[31:16];
    wr1.pc = {r.fetch_pc[31:2], 2'b10};
    we0    = accept;
    we1    = accept && !r.fetch_pc[1];
    push_n = {1'b0, we0} + {1'b0, we1};

    head_c          = is_compressed(rd0.hw);
    have_instr      = head_c ? (count >= cnt_t'(1)) : (count >= cnt_t'(2));
    d_out.out_valid = have_instr && !d_in.redirect;
    d_out.out_pc    = d_out.out_valid ? rd0.pc : 32'h0;
    d_out.out_instr = !d_out.out_valid ? 32'h0 :
                      head_c ? {16'h0, rd0.hw} : {rd1_hw, rd0.hw};
    pop_n           = (d_out.out_valid && !d_in.out_stall) ? (head_c ? 2'd1 : 2'd2) : 2'd0;

    d_out.mem_valid = !r.pend && (free >= cnt_t'(2)) && !d_in.redirect;
    d_out.mem_addr  = {r.fetch_pc[31:2], 2'b00};
    d_out.mem_spec  = r.spec_f;
    d_out.mem_fence = r.fence_f;
  end

  always_comb begin
    rin     = r;
    head_n  = head + ptr_t'(pop_n);
    tail_n  = tail + ptr_t'(push_n);
    count_n = count + cnt_t'(push_n) - cnt_t'(pop_n);

    if (d_out.mem_valid) begin
      rin.pend    = 1'b1;
      rin.spec_f  = 1'b0;
      rin.fence_f = 1'b0;
    end

    if (resp) begin
      rin.pend = 1'b0;
      rin.drop = 1'b0;
      if (!r.drop) rin.fetch_pc = {r.fetch_pc[31:2] + 30'd1, 2'b00};
    end

    // A response still in flight at redirect time belongs to the old stream; mark it for discard.
    if (d_in.redirect) begin
      head_n      = '0;
      tail_n      = '0;
      count_n     = '0;
      rin.fetch_pc = d_in.redirect_pc;
      rin.spec_f  = 1'b1;
      rin.fence_f = d_in.redirect_fence;
      rin.pend    = r.pend && !d_in.mem_ready;
      rin.drop    = r.pend && !d_in.mem_ready;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r     <= init_fetch_queue_reg(RESET_PC);
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      r     <= rin;
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
    end
  end

  fetch_align_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock     (clock),
    .we0       (we0 && reset),
    .waddr0    (tail),
    .wdata0    (wr0),
    .we1       (we1 && reset),
    .waddr1    (tail + ptr_t'(1)),
    .wdata1    (wr1),
    .raddr0    (head),
    .rdata0    (rd0),
    .raddr1    (head + ptr_t'(1)),
    .rdata1_hw (rd1_hw)
  );

  assign bus.mem_valid = d_out.mem_valid;
  assign bus.mem_addr  = d_out.mem_addr;
  assign bus.mem_spec  = d_out.mem_spec;
  assign bus.mem_fence = d_out.mem_fence;
  assign bus.out_valid = d_out.out_valid;
  assign bus.out_pc    = d_out.out_pc;
  assign bus.out_instr = d_out.out_instr;

endmodule
